// File: rtl/label_resolver_pkg.sv
// ---------------------------------------------------------------------------
// label_resolver_pkg
//   Shared definitions for the connected-components second pass:
//   default label width and the resolver phase encoding.
// ---------------------------------------------------------------------------
package label_resolver_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [1:0] {
    LR_INIT    = 2'd0,
    LR_COLLECT = 2'd1,
    LR_FLATTEN = 2'd2,
    LR_RELABEL = 2'd3
  } lr_state_e;

  // The table is unavailable to the outside world while it is being
  // (re)written wholesale.
  function automatic logic lr_is_busy(lr_state_e s);
    return (s == LR_INIT) || (s == LR_FLATTEN);
  endfunction

endpackage

// File: rtl/label_resolver_table.sv
// ---------------------------------------------------------------------------
// label_table
//   Equivalence table: LABEL_W-bit entries, 2^LABEL_W deep.
//   One write port, two read ports, both reads registered (data one cycle
//   after the address). A read of the address being written in the same
//   cycle returns the old contents; the resolver never depends on that case.
//
//   clk, rst          clock, async active-high reset (read registers only)
//   we_i/waddr_i/wdata_i   write port
//   raddr_a_i/rdata_a_o    read port A
//   raddr_b_i/rdata_b_o    read port B
// ---------------------------------------------------------------------------
module label_table #(
  parameter int LABEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [LABEL_W-1:0] waddr_i,
  input  logic [LABEL_W-1:0] wdata_i,
  input  logic [LABEL_W-1:0] raddr_a_i,
  input  logic [LABEL_W-1:0] raddr_b_i,
  output logic [LABEL_W-1:0] rdata_a_o,
  output logic [LABEL_W-1:0] rdata_b_o
);

  localparam int DEPTH = 1 << LABEL_W;

  // No reset on the array: the resolver's INIT phase writes every entry.
  logic [LABEL_W-1:0] mem_q [0:DEPTH-1];
  logic [LABEL_W-1:0] rd_a_q, rd_b_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= mem_q[raddr_a_i];
      rd_b_q <= mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rd_a_q;
  assign rdata_b_o = rd_b_q;

endmodule

// File: rtl/label_resolver.sv
// ---------------------------------------------------------------------------
// label_resolver
//   Second pass of connected-components labelling. Collects merge pairs
//   from the first pass into an equivalence table, compresses every chain
//   to its root, then maps a stream of provisional labels to final labels.
//   Phases: INIT (identity fill) -> COLLECT -> FLATTEN -> RELABEL -> INIT.
//
//   clk, reset                 clock, async active-high reset
//   merge_valid/max/min        merge pair in, merge_ready handshake out
//   num_labels, frame_done     label count, sampled on the frame_done pulse
//   pix_valid/label/last       provisional label stream in
//   out_valid/label/last       resolved label stream out, latency 1
//   busy                       high during INIT and FLATTEN
//   err                        sticky protocol error flag
// ---------------------------------------------------------------------------
module label_resolver
  import label_resolver_pkg::*;
#(
  parameter int LABEL_W = WORD_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               merge_valid,
  input  logic [LABEL_W-1:0] merge_max,
  input  logic [LABEL_W-1:0] merge_min,
  output logic               merge_ready,
  input  logic [LABEL_W-1:0] num_labels,
  input  logic               frame_done,
  input  logic               pix_valid,
  input  logic [LABEL_W-1:0] pix_label,
  input  logic               pix_last,
  output logic               out_valid,
  output logic [LABEL_W-1:0] out_label,
  output logic               out_last,
  output logic               busy,
  output logic               err
);

  localparam logic [LABEL_W:0] IDX_LAST = {1'b0, {LABEL_W{1'b1}}};
  localparam logic [LABEL_W:0] IDX_ONE  = (LABEL_W+1)'(1);

  lr_state_e          state_q, state_d;
  logic [LABEL_W:0]   idx_q, idx_d;       // INIT fill address
  logic               mphase_q, mphase_d; // merge in its write cycle
  logic               mbad_q, mbad_d;     // accepted pair was malformed
  logic               fdone_q, fdone_d;   // frame_done seen, waiting for merge to drain
  logic [LABEL_W-1:0] n_q, n_d;
  logic [LABEL_W:0]   fidx_q, fidx_d;     // FLATTEN entry being read
  logic               fph_q, fph_d;       // FLATTEN sub-cycle
  logic               fpend_q, fpend_d;   // a FLATTEN write-back is outstanding
  logic [LABEL_W-1:0] widx_q, widx_d;     // entry owed that write-back
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               err_q, err_d;

  logic               we;
  logic [LABEL_W-1:0] waddr, wdata, raddr_a, raddr_b, rd_a, rd_b;
  logic               merge_hs, bad_merge;
  logic [LABEL_W-1:0] root_hi, root_lo;

  label_table #(.LABEL_W(LABEL_W)) u_table (
    .clk       (clk),
    .rst       (reset),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (raddr_a),
    .raddr_b_i (raddr_b),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // Once frame_done is seen no further merges are taken, so the last one
  // in flight finishes before FLATTEN begins.
  assign merge_ready = (state_q == LR_COLLECT) && !mphase_q && !fdone_q;
  assign merge_hs    = merge_valid && merge_ready;
  assign bad_merge   = (merge_min == '0) || (merge_min >= merge_max);

  assign root_hi = (rd_a > rd_b) ? rd_a : rd_b;
  assign root_lo = (rd_a > rd_b) ? rd_b : rd_a;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mphase_d    = 1'b0;
    mbad_d      = mbad_q;
    fdone_d     = fdone_q;
    n_d         = n_q;
    fidx_d      = fidx_q;
    fph_d       = fph_q;
    fpend_d     = fpend_q;
    widx_d      = widx_q;
    err_d       = err_q;
    we          = 1'b0;
    waddr       = '0;
    wdata       = '0;
    raddr_a     = pix_label;
    raddr_b     = '0;
    out_valid_d = pix_valid && (state_q == LR_RELABEL);
    out_last_d  = pix_valid && pix_last && (state_q == LR_RELABEL);

    if (frame_done && (state_q != LR_COLLECT)) err_d = 1'b1;

    case (state_q)
      LR_INIT: begin
        we    = 1'b1;
        waddr = idx_q[LABEL_W-1:0];
        wdata = idx_q[LABEL_W-1:0];
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = LR_COLLECT;
          fdone_d = 1'b0;
        end
      end

      LR_COLLECT: begin
        // Cycle 1: fetch both current table entries.
        if (merge_hs) begin
          raddr_a  = merge_max;
          raddr_b  = merge_min;
          mphase_d = 1'b1;
          mbad_d   = bad_merge;
          if (bad_merge) err_d = 1'b1;
        end
        // Cycle 2: hang the larger of the two on the smaller, which keeps
        // table[i] <= i so FLATTEN can resolve in one ascending pass.
        if (mphase_q && !mbad_q && (rd_a != rd_b)) begin
          we    = 1'b1;
          waddr = root_hi;
          wdata = root_lo;
        end
        if (frame_done) begin
          n_d     = num_labels;
          fdone_d = 1'b1;
        end
        if (fdone_q && !mphase_q) begin
          state_d = LR_FLATTEN;
          fidx_d  = IDX_ONE;
          fph_d   = 1'b0;
          fpend_d = 1'b0;
        end
      end

      LR_FLATTEN: begin
        // Pipelined two cycles per entry: sub-cycle 0 reads p=table[idx]
        // and retires the previous entry's write; sub-cycle 1 reads table[p].
        if (!fph_q) begin
          if (fpend_q) begin
            we    = 1'b1;
            waddr = widx_q;
            wdata = rd_b;
          end
          fpend_d = 1'b0;
          if (fidx_q < {1'b0, n_q}) begin
            raddr_a = fidx_q[LABEL_W-1:0];
            fph_d   = 1'b1;
          end else begin
            state_d = LR_RELABEL;
          end
        end else begin
          raddr_b = rd_a;
          widx_d  = fidx_q[LABEL_W-1:0];
          fpend_d = 1'b1;
          fidx_d  = fidx_q + 1'b1;
          fph_d   = 1'b0;
        end
      end

      LR_RELABEL: begin
        if (pix_valid && pix_last) begin
          state_d = LR_INIT;
          idx_d   = '0;
        end
      end

      default: state_d = LR_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LR_INIT;
      idx_q       <= '0;
      mphase_q    <= 1'b0;
      mbad_q      <= 1'b0;
      fdone_q     <= 1'b0;
      n_q         <= '0;
      fidx_q      <= '0;
      fph_q       <= 1'b0;
      fpend_q     <= 1'b0;
      widx_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mphase_q    <= mphase_d;
      mbad_q      <= mbad_d;
      fdone_q     <= fdone_d;
      n_q         <= n_d;
      fidx_q      <= fidx_d;
      fph_q       <= fph_d;
      fpend_q     <= fpend_d;
      widx_q      <= widx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  // Port A's registered read is the output register in RELABEL.
  assign out_valid = out_valid_q;
  assign out_label = out_valid_q ? rd_a : '0;
  assign out_last  = out_last_q;
  assign busy      = lr_is_busy(state_q);
  assign err       = err_q;

endmodule

// File: tb/tb_label_resolver.sv
module tb_label_resolver;

  localparam int LW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          merge_valid;
  logic [LW-1:0] merge_max, merge_min;
  logic          merge_ready;
  logic [LW-1:0] num_labels;
  logic          frame_done;
  logic          pix_valid;
  logic [LW-1:0] pix_label;
  logic          pix_last;
  logic          out_valid;
  logic [LW-1:0] out_label;
  logic          out_last;
  logic          busy;
  logic          err;

  label_resolver dut (
    .clk(clk), .reset(reset),
    .merge_valid(merge_valid), .merge_max(merge_max), .merge_min(merge_min),
    .merge_ready(merge_ready),
    .num_labels(num_labels), .frame_done(frame_done),
    .pix_valid(pix_valid), .pix_label(pix_label), .pix_last(pix_last),
    .out_valid(out_valid), .out_label(out_label), .out_last(out_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: the equivalence table as a plain array, updated by the rules.
  int          tbl [DEPTH];
  bit          exp_err;
  logic [LW:0] exp_q [$];   // {last, label}
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void check(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endfunction

  function automatic void model_init();
    for (int i = 0; i < DEPTH; i++) tbl[i] = i;
  endfunction

  function automatic void model_merge(input int mx, input int mn);
    int ra, rb;
    if (mn == 0 || mn >= mx) begin
      exp_err = 1'b1;
      return;
    end
    ra = tbl[mx];
    rb = tbl[mn];
    if (ra > rb) tbl[ra] = rb;
    else if (rb > ra) tbl[rb] = ra;
  endfunction

  function automatic void model_flatten(input int n);
    for (int i = 1; i < n; i++) tbl[i] = tbl[tbl[i]];
  endfunction

  // Monitor: every output beat must match the oldest expectation.
  always @(negedge clk) begin
    logic [LW:0] e;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("out_without_expect", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("out_label", out_label, e[LW-1:0]);
          check("out_last", out_last, e[LW]);
        end
      end else if (out_last) begin
        check("out_last_without_valid", out_last, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input bit lvl, input int lim, input string nm);
    int c;
    bit ok;
    c = 0;
    ok = 1'b0;
    while (c < lim && !ok) begin
      @(negedge clk);
      if (busy == lvl) ok = 1'b1;
      c++;
    end
    check(nm, ok, 1);
    tick();
  endtask

  // Counts busy cycles of an INIT phase that starts at the current cycle.
  task automatic wait_init();
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < 600) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else c++;
    end
    check("init_busy_cycles", c, 256);
    check("merge_ready_after_init", merge_ready, 1);
    tick();
  endtask

  task automatic send_merge(input int mx, input int mn, output int t);
    bit hs;
    hs = 1'b0;
    t = 0;
    merge_valid = 1'b1;
    merge_max = LW'(mx);
    merge_min = LW'(mn);
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = merge_ready;
      @(posedge clk);
      #1;
      t++;
    end
    merge_valid = 1'b0;
    check("merge_accepted", hs, 1);
    if (hs) model_merge(mx, mn);
  endtask

  task automatic end_frame(input int n, input bit extra_fd);
    frame_done = 1'b1;
    num_labels = LW'(n);
    tick();
    frame_done = 1'b0;
    model_flatten(n);
    wait_busy(1'b1, 20, "flatten_start");
    if (extra_fd) begin
      frame_done = 1'b1;
      num_labels = LW'(3);
      tick();
      frame_done = 1'b0;
      exp_err = 1'b1;
      tick();
      check("err_fd_in_flatten", err, 1);
    end
    wait_busy(1'b0, 1200, "flatten_end");
  endtask

  // want < 0: take the expected label from the reference table.
  task automatic push_pix(input int l, input bit last, input int want);
    int w;
    w = (want < 0) ? tbl[l] : want;
    exp_q.push_back({last, w[LW-1:0]});
    pix_valid = 1'b1;
    pix_label = LW'(l);
    pix_last  = last;
    tick();
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    if (last) begin
      check("busy_after_last", busy, 1);
      check("err_state", err, exp_err);
      model_init();
      wait_init();
    end
  endtask

  task automatic rand_frame();
    int n, mx, mn, t, np;
    n = $urandom_range(3, 80);
    repeat ($urandom_range(0, 2 * n)) begin
      mx = $urandom_range(2, n - 1);
      mn = $urandom_range(1, mx - 1);
      case ($urandom_range(0, 19))
        0: mn = 0;
        1: mn = mx;
        default: ;
      endcase
      send_merge(mx, mn, t);
      if ($urandom_range(0, 3) == 0) tick();
    end
    end_frame(n, 1'b0);
    np = $urandom_range(5, 30);
    for (int p = 0; p < np; p++) begin
      if ($urandom_range(0, 3) == 0) tick();
      push_pix($urandom_range(0, n + 4), p == np - 1, -1);
    end
  endtask

  initial begin
    int t;
    merge_valid = 1'b0; merge_max = '0; merge_min = '0;
    num_labels = '0; frame_done = 1'b0;
    pix_valid = 1'b0; pix_label = '0; pix_last = 1'b0;
    reset = 1'b1;
    exp_err = 1'b0;
    model_init();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_merge_ready", merge_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_label", out_label, 0);
    check("rst_out_last", out_last, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    wait_init();

    // Identity frame; pixels offered in COLLECT must be ignored.
    pix_valid = 1'b1; pix_label = LW'(3);
    tick(); tick();
    pix_valid = 1'b0;
    end_frame(4, 1'b0);
    push_pix(1, 1'b0, 1);
    push_pix(2, 1'b0, 2);
    push_pix(3, 1'b1, 3);

    // Chain.
    send_merge(3, 2, t);
    send_merge(2, 1, t);
    end_frame(4, 1'b0);
    push_pix(3, 1'b0, 1);
    push_pix(2, 1'b0, 1);
    push_pix(1, 1'b0, 1);
    push_pix(0, 1'b1, 0);

    // Cross-root merge.
    send_merge(5, 4, t);
    send_merge(6, 2, t);
    send_merge(6, 5, t);
    end_frame(7, 1'b0);
    push_pix(4, 1'b0, 2);
    push_pix(6, 1'b0, 2);
    push_pix(3, 1'b0, 3);
    push_pix(5, 1'b1, 2);

    // Back-to-back merges: one accepted every second cycle.
    for (int i = 0; i < 10; i++) begin
      int mx, mn;
      mx = $urandom_range(2, 39);
      mn = $urandom_range(1, mx - 1);
      send_merge(mx, mn, t);
      if (i > 0) check("b2b_spacing", t, 2);
    end
    end_frame(40, 1'b0);
    for (int p = 0; p < 20; p++) push_pix($urandom_range(0, 45), p == 19, -1);
    check("err_clean", err, 0);

    // frame_done during FLATTEN: flagged and ignored.
    send_merge(9, 4, t);
    send_merge(100, 9, t);
    send_merge(50, 3, t);
    end_frame(120, 1'b1);
    push_pix(100, 1'b0, 4);
    push_pix(9, 1'b0, 4);
    push_pix(50, 1'b0, 3);
    push_pix(110, 1'b1, -1);

    // Reset in the middle of FLATTEN.
    send_merge(7, 2, t);
    frame_done = 1'b1; num_labels = LW'(200);
    tick();
    frame_done = 1'b0;
    wait_busy(1'b1, 20, "flatten_start_rst");
    repeat (10) tick();
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 1);
    check("midrst_merge_ready", merge_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_label", out_label, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_err", err, 0);
    exp_err = 1'b0;
    model_init();
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    wait_init();
    end_frame(0, 1'b0);
    for (int p = 0; p < 10; p++) push_pix($urandom_range(0, 255), p == 9, -1);

    // Malformed merges: flagged, dropped.
    send_merge(2, 3, t);
    exp_err = 1'b1;
    check("err_bad_merge", err, 1);
    send_merge(5, 0, t);
    send_merge(4, 4, t);
    send_merge(5, 1, t);
    send_merge(7, 5, t);
    end_frame(8, 1'b0);
    push_pix(5, 1'b0, 1);
    push_pix(7, 1'b0, 1);
    push_pix(3, 1'b0, 3);
    push_pix(2, 1'b0, 2);
    push_pix(4, 1'b1, 4);

    repeat (4) rand_frame();

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
